// File: rtl/pbus_pkg.sv
// rtl/pbus_pkg.sv - shared FSM states, register offsets and bit positions for the bus mailbox target
package pbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DECODE,
    ST_READ,
    ST_WRITE,
    ST_ERR
  } pbus_state_e;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;
  localparam logic [1:0] REG_SCRATCH = 2'd3;

  localparam int STS_TX_FULL  = 0;
  localparam int STS_TX_EMPTY = 1;
  localparam int STS_RX_EMPTY = 2;
  localparam int STS_RX_FULL  = 3;
  localparam int STS_OVF      = 4;
  localparam int STS_UDF      = 5;

  localparam int CTRL_TX_EN   = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_IRQ_EN  = 2;
  localparam int CTRL_OVF_CLR = 4;
  localparam int CTRL_UDF_CLR = 5;

endpackage

// File: rtl/pbus_if.sv
// rtl/pbus_if.sv - multiplexed 20-bit address/data CPU bus; master = CPU, slave = target
interface pbus_if #(
  parameter int DW = 16
);
  logic          ale;
  logic          oe_n;
  logic          we_n;
  logic          pio;
  logic [15:0]   ad_i;
  logic [3:0]    a_hi;
  logic [DW-1:0] ad_o;
  logic          ad_oe;

  modport master (output ale, oe_n, we_n, pio, ad_i, a_hi, input ad_o, ad_oe);
  modport slave  (input ale, oe_n, we_n, pio, ad_i, a_hi, output ad_o, ad_oe);
endinterface

// File: rtl/pbus_fifo.sv
// rtl/pbus_fifo.sv - synchronous FIFO with push, pop and flush; push into a full FIFO succeeds only alongside a pop
module pbus_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_q;
  logic [AW:0]   rd_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/pbus_mailbox_target.sv
// rtl/pbus_mailbox_target.sv - bus target with DATA/STATUS/CTRL/SCRATCH regs and tx/rx mailbox FIFOs
// Define PBUS_TGT_IRQ_EN to add the irq output and the CTRL irq_en bit.
module pbus_mailbox_target
  import pbus_pkg::*;
#(
  parameter logic [19:0] BASE_ADDR  = 20'hF0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          DW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  pbus_if.slave         bus,
  output logic [DW-1:0] tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  output logic          rx_ready
`ifdef PBUS_TGT_IRQ_EN
  ,
  output logic          irq
`endif
);
  pbus_state_e   state_q;
  logic [19:0]   addr_q;
  logic [DW-1:0] wdata_q, rdata_q, scratch_q, scratch_d, reg_rdata, rx_head;
  logic          ad_oe_q, rd_empty_q;
  logic          tx_en_q, tx_en_d, irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          hit, commit, rd_done, ctrl_wr, flush;
  logic          tx_push, tx_pop, rx_push, rx_pop, ovf_set, udf_set;
  logic [1:0]    reg_sel;

  assign reg_sel  = addr_q[1:0];
  assign hit      = bus.pio && (addr_q[19:2] == BASE_ADDR[19:2]);
  assign commit   = (state_q == ST_WRITE) && !bus.ale && bus.we_n;
  assign rd_done  = (state_q == ST_READ) && !bus.ale && bus.oe_n;
  assign ctrl_wr  = commit && (reg_sel == REG_CTRL);
  assign flush    = ctrl_wr && wdata_q[CTRL_FLUSH];
  assign tx_valid = tx_en_q && !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = commit && (reg_sel == REG_DATA);
  assign ovf_set  = tx_push && tx_full && !tx_pop;
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  // Emptiness is judged at read entry so the pop matches the word that was returned.
  assign rx_pop   = rd_done && (reg_sel == REG_DATA) && !rd_empty_q;
  assign udf_set  = rd_done && (reg_sel == REG_DATA) && rd_empty_q;

  assign bus.ad_o  = rdata_q;
  assign bus.ad_oe = ad_oe_q;

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      REG_DATA:   reg_rdata = rx_empty ? '0 : rx_head;
      REG_STATUS: begin
        reg_rdata[STS_TX_FULL]  = tx_full;
        reg_rdata[STS_TX_EMPTY] = tx_empty;
        reg_rdata[STS_RX_EMPTY] = rx_empty;
        reg_rdata[STS_RX_FULL]  = rx_full;
        reg_rdata[STS_OVF]      = ovf_q;
        reg_rdata[STS_UDF]      = udf_q;
      end
      REG_CTRL: begin
        reg_rdata[CTRL_TX_EN]  = tx_en_q;
        reg_rdata[CTRL_IRQ_EN] = irq_en_q;
      end
      default:    reg_rdata = scratch_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      ad_oe_q    <= 1'b0;
      rd_empty_q <= 1'b0;
    end else if (bus.ale) begin
      state_q <= ST_ADDR;
      addr_q  <= {bus.a_hi, bus.ad_i};
      ad_oe_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ADDR:   state_q <= ST_DECODE;
        ST_DECODE: begin
          if (!hit) begin
            state_q <= ST_IDLE;
          end else if (!bus.oe_n && !bus.we_n) begin
            state_q <= ST_ERR;
          end else if (!bus.oe_n) begin
            state_q    <= ST_READ;
            rdata_q    <= reg_rdata;
            rd_empty_q <= rx_empty;
            ad_oe_q    <= 1'b1;
          end else if (!bus.we_n) begin
            state_q <= ST_WRITE;
            wdata_q <= bus.ad_i;
          end
        end
        ST_READ: begin
          if (bus.oe_n) begin
            state_q <= ST_IDLE;
            ad_oe_q <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (bus.we_n) state_q <= ST_IDLE;
          else          wdata_q <= bus.ad_i;
        end
        ST_ERR:    if (bus.oe_n && bus.we_n) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_en_d   = tx_en_q;
    irq_en_d  = irq_en_q;
    scratch_d = scratch_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    if (ctrl_wr) begin
      tx_en_d = wdata_q[CTRL_TX_EN];
`ifdef PBUS_TGT_IRQ_EN
      irq_en_d = wdata_q[CTRL_IRQ_EN];
`endif
      if (wdata_q[CTRL_OVF_CLR]) ovf_d = 1'b0;
      if (wdata_q[CTRL_UDF_CLR]) udf_d = 1'b0;
    end
    if (commit && (reg_sel == REG_SCRATCH)) scratch_d = wdata_q;
    // Sticky set wins over a same-cycle W1C.
    if (ovf_set) ovf_d = 1'b1;
    if (udf_set) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_en_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      scratch_q <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      tx_en_q   <= tx_en_d;
      irq_en_q  <= irq_en_d;
      scratch_q <= scratch_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

`ifdef PBUS_TGT_IRQ_EN
  logic irq_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= (irq_en_q && !rx_empty) || ovf_q || udf_q;
  end
  assign irq = irq_q;
`endif

  pbus_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .pop_i(tx_pop), .flush_i(flush),
    .wdata_i(wdata_q), .rdata_o(tx_data), .full_o(tx_full), .empty_o(tx_empty)
  );

  pbus_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .pop_i(rx_pop), .flush_i(flush),
    .wdata_i(rx_data), .rdata_o(rx_head), .full_o(rx_full), .empty_o(rx_empty)
  );
endmodule

// File: tb/tb_pbus_mailbox_target.sv
// tb/tb_pbus_mailbox_target.sv - directed bench with a queue-based mailbox model and per-cycle output compare
module tb_pbus_mailbox_target;
  localparam logic [19:0] BASE   = 20'hF0000;
  localparam logic [19:0] A_DATA = BASE;
  localparam logic [19:0] A_STAT = BASE + 20'd1;
  localparam logic [19:0] A_CTRL = BASE + 20'd2;
  localparam logic [19:0] A_SCR  = BASE + 20'd3;
  localparam logic [19:0] A_MISS = BASE + 20'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pbus_if #(.DW(16)) bus ();
  logic [15:0] tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;
`ifdef PBUS_TGT_IRQ_EN
  logic        irq;
`endif

  pbus_mailbox_target #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
`ifdef PBUS_TGT_IRQ_EN
    , .irq(irq)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  // Model state: FIFOs as queues, registers as plain variables.
  logic [15:0] m_tx[$];
  logic [15:0] m_rx[$];
  logic        m_tx_en = 1'b0, m_irq_en = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  logic        m_oe = 1'b0, m_irq = 1'b0;
  logic [15:0] m_scratch = 16'h0, m_rdata = 16'h0;
  logic        ev_wr = 1'b0, ev_rd_enter = 1'b0, ev_rd_exit = 1'b0;
  logic [1:0]  ev_reg = 2'd0;
  logic [15:0] ev_data = 16'h0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_reg(input logic [1:0] r);
    case (r)
      2'd0:    return (m_rx.size() != 0) ? m_rx[0] : 16'h0000;
      2'd1:    return {10'b0, m_udf, m_ovf, m_rx.size() == 8, m_rx.size() == 0,
                       m_tx.size() == 0, m_tx.size() == 8};
      2'd2:    return {13'b0, m_irq_en, 1'b0, m_tx_en};
      default: return m_scratch;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic tpop, rpush, fl;
    if (rst) begin
      m_tx.delete(); m_rx.delete();
      m_tx_en = 1'b0; m_irq_en = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
      m_oe = 1'b0; m_irq = 1'b0; m_scratch = 16'h0; m_rdata = 16'h0;
    end else begin
      m_irq = (m_irq_en && m_rx.size() != 0) || m_ovf || m_udf;
      tpop  = m_tx_en && m_tx.size() != 0 && tx_ready;
      rpush = rx_valid && m_rx.size() < 8;
      fl    = 1'b0;
      if (bus.ale) m_oe = 1'b0;
      if (ev_rd_enter) begin
        m_rdata = m_reg(ev_reg);
        m_oe    = 1'b1;
      end
      if (ev_rd_exit) begin
        m_oe = 1'b0;
        if (ev_reg == 2'd0) begin
          if (m_rx.size() == 0) m_udf = 1'b1;
          else void'(m_rx.pop_front());
        end
      end
      if (tpop) void'(m_tx.pop_front());
      if (ev_wr) begin
        case (ev_reg)
          2'd0: if (m_tx.size() < 8) m_tx.push_back(ev_data); else m_ovf = 1'b1;
          2'd2: begin
            m_tx_en = ev_data[0];
            fl      = ev_data[1];
`ifdef PBUS_TGT_IRQ_EN
            m_irq_en = ev_data[2];
`endif
            if (ev_data[4]) m_ovf = 1'b0;
            if (ev_data[5]) m_udf = 1'b0;
          end
          2'd3: m_scratch = ev_data;
          default: ;
        endcase
      end
      if (fl) begin
        m_tx.delete(); m_rx.delete();
      end else if (rpush) begin
        m_rx.push_back(rx_data);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("ad_oe", {15'b0, bus.ad_oe}, {15'b0, m_oe});
      if (m_oe) chk("ad_o", bus.ad_o, m_rdata);
      chk("tx_valid", {15'b0, tx_valid}, {15'b0, m_tx_en && m_tx.size() != 0});
      if (m_tx_en && m_tx.size() != 0) chk("tx_data", tx_data, m_tx[0]);
      chk("rx_ready", {15'b0, rx_ready}, {15'b0, m_rx.size() < 8});
`ifdef PBUS_TGT_IRQ_EN
      chk("irq", {15'b0, irq}, {15'b0, m_irq});
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_hit(input logic [19:0] a, input logic p);
    return p && ((a >> 2) == (BASE >> 2));
  endfunction

  task automatic bus_addr(input logic [19:0] a, input logic p);
    bus.ale = 1'b1; bus.a_hi = a[19:16]; bus.ad_i = a[15:0]; bus.pio = p;
    step();
    bus.ale = 1'b0; bus.ad_i = 16'h0;
    step();
  endtask

  task automatic write_phase(input logic [19:0] a, input logic [15:0] d, input logic h);
    bus.we_n = 1'b0; bus.ad_i = d;
    step();
    step();
    bus.we_n = 1'b1; ev_wr = h; ev_reg = a[1:0]; ev_data = d;
    step();
    ev_wr = 1'b0; bus.pio = 1'b0; bus.ad_i = 16'h0;
  endtask

  task automatic read_phase(input logic [19:0] a, input logic h,
                            output logic [15:0] rd, output logic seen);
    bus.oe_n = 1'b0; ev_rd_enter = h; ev_reg = a[1:0];
    step();
    ev_rd_enter = 1'b0; rd = bus.ad_o; seen = bus.ad_oe;
    step();
    bus.oe_n = 1'b1; ev_rd_exit = h;
    step();
    ev_rd_exit = 1'b0; bus.pio = 1'b0;
  endtask

  task automatic bus_write(input logic [19:0] a, input logic p, input logic [15:0] d);
    bus_addr(a, p);
    write_phase(a, d, is_hit(a, p));
  endtask

  task automatic bus_read(input logic [19:0] a, input logic p,
                          output logic [15:0] rd, output logic seen);
    bus_addr(a, p);
    read_phase(a, is_hit(a, p), rd, seen);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    logic [15:0] rd;
    logic        seen;
    logic [15:0] got[$];
    logic [19:0] av;
    bus.ale = 1'b0; bus.oe_n = 1'b1; bus.we_n = 1'b1; bus.pio = 1'b0;
    bus.ad_i = 16'h0; bus.a_hi = 4'h0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 16'h0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    chk_en = 1'b1;

    chk("rst_ad_oe", {15'b0, bus.ad_oe}, 16'h0);
    chk("rst_ad_o", bus.ad_o, 16'h0);
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("rst_status", rd, 16'h0006);

    // scratch round trip
    bus_write(A_SCR, 1'b1, 16'hBEEF);
    bus_read(A_SCR, 1'b1, rd, seen);
    chk("scratch_rd", rd, 16'hBEEF);
    chk("scratch_oe", {15'b0, seen}, 16'h0001);

    // tx overflow then ordered drain
    bus_write(A_CTRL, 1'b1, 16'h0001);
    for (int i = 0; i < 9; i++) bus_write(A_DATA, 1'b1, 16'(16'h1000 + i));
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("status_ovf_full", rd, 16'h0015);
    tx_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (tx_valid) got.push_back(tx_data);
    end
    tx_ready = 1'b0;
    chk("drain_cnt", 16'(got.size()), 16'd8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("drain_word", got[i], 16'(16'h1000 + i));
    bus_write(A_CTRL, 1'b1, 16'h0011);
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("status_ovf_clr", rd, 16'h0006);

    // rx underflow, W1C, then a real word
    bus_read(A_DATA, 1'b1, rd, seen);
    chk("rx_empty_rd", rd, 16'h0000);
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("status_udf", rd, 16'h0026);
    bus_write(A_CTRL, 1'b1, 16'h0021);
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("status_udf_clr", rd, 16'h0006);
    rx_valid = 1'b1; rx_data = 16'h1234;
    step();
    rx_valid = 1'b0;
    bus_read(A_DATA, 1'b1, rd, seen);
    chk("rx_word", rd, 16'h1234);

    // rx fill to full, then flush
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1; rx_data = 16'(16'h2000 + i);
      step();
    end
    rx_valid = 1'b0;
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("status_rx_full", rd, 16'h000A);
    bus_read(A_DATA, 1'b1, rd, seen);
    chk("rx_first", rd, 16'h2000);
    bus_write(A_CTRL, 1'b1, 16'h0002);
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("status_flush", rd, 16'h0006);
    bus_read(A_CTRL, 1'b1, rd, seen);
    chk("ctrl_rd", rd, 16'h0000);

    // non-hits
    bus_write(A_SCR, 1'b0, 16'h5555);
    bus_write(A_MISS, 1'b1, 16'h6666);
    bus_read(A_MISS, 1'b1, rd, seen);
    chk("miss_oe", {15'b0, seen}, 16'h0000);
    bus_read(A_SCR, 1'b0, rd, seen);
    chk("pio0_oe", {15'b0, seen}, 16'h0000);
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("miss_status", rd, 16'h0006);
    bus_read(A_SCR, 1'b1, rd, seen);
    chk("miss_scratch", rd, 16'hBEEF);

    // ale during WRITE aborts the commit
    bus_addr(A_SCR, 1'b1);
    bus.we_n = 1'b0; bus.ad_i = 16'hDEAD;
    step();
    step();
    av = A_SCR;
    bus.ale = 1'b1; bus.a_hi = av[19:16]; bus.ad_i = av[15:0]; bus.pio = 1'b1;
    step();
    bus.ale = 1'b0; bus.we_n = 1'b1; bus.ad_i = 16'h0;
    step();
    read_phase(A_SCR, 1'b1, rd, seen);
    chk("abort_scratch", rd, 16'hBEEF);
    chk("abort_oe", {15'b0, seen}, 16'h0001);

    // reset while driving
    bus_write(A_DATA, 1'b1, 16'h7777);
    rx_valid = 1'b1; rx_data = 16'h4444;
    step();
    rx_valid = 1'b0;
    bus_addr(A_SCR, 1'b1);
    bus.oe_n = 1'b0; ev_rd_enter = 1'b1; ev_reg = 2'd3;
    step();
    ev_rd_enter = 1'b0;
    chk("pre_rst_oe", {15'b0, bus.ad_oe}, 16'h0001);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_oe", {15'b0, bus.ad_oe}, 16'h0000);
    step();
    bus.oe_n = 1'b1; bus.pio = 1'b0;
    step();
    rst = 1'b0;
    step();
    bus_read(A_STAT, 1'b1, rd, seen);
    chk("post_rst_status", rd, 16'h0006);
    bus_read(A_SCR, 1'b1, rd, seen);
    chk("post_rst_scratch", rd, 16'h0000);

    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
